// File: rtl/zero_run_detector.sv
// zero_run_detector: registered zero flag plus saturating zero-run counter with threshold hit; optional ZRD_MASK_EN adds a bit mask; ports clk, rst, clear, in_valid, a, [mask], zero, run_count, run_hit, hit_pulse
module zero_run_detector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int THRESHOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
`ifdef ZRD_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic             zero,
  output logic [CNT_W-1:0] run_count,
  output logic             run_hit,
  output logic             hit_pulse
);
  if (THRESHOLD < 1 || THRESHOLD > 2 ** CNT_W - 1) begin : g_bad_threshold
    $error("zero_run_detector: THRESHOLD out of range 1..2^CNT_W-1");
  end
  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic zero_q, zero_d, pulse_q, pulse_d, z;
`ifdef ZRD_MASK_EN
  assign z = (a & mask) == '0;
`else
  assign z = a == '0;
`endif
  always_comb begin
    count_inc = count_q == MAX ? count_q : count_q + 1'b1;
    zero_d = in_valid ? z : zero_q;
    count_d = in_valid ? (z ? count_inc : '0) : count_q;
    state_d = !in_valid ? state_q : !z ? IDLE : count_inc >= THR ? HIT : RUN;
    pulse_d = in_valid && z && state_q != HIT && count_inc >= THR;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      count_q <= '0;
      zero_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      zero_q <= zero_d;
      pulse_q <= pulse_d;
    end
  end
  assign zero = zero_q;
  assign run_count = count_q;
  assign run_hit = state_q == HIT;
  assign hit_pulse = pulse_q;
endmodule

// File: tb/tb_zero_run_detector.sv
// tb_zero_run_detector: table-driven and sequence checks of zero_run_detector (THRESHOLD=4 and THRESHOLD=1 instances)
module tb_zero_run_detector;
  logic clk = 1'b0;
  logic rst = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] mask = '1;
  logic zero, run_hit, hit_pulse, zero1, run_hit1, hit_pulse1;
  logic [3:0] run_count, run_count1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  zero_run_detector #(.WIDTH(8), .CNT_W(4), .THRESHOLD(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a),
`ifdef ZRD_MASK_EN
    .mask(mask),
`endif
    .zero(zero), .run_count(run_count), .run_hit(run_hit), .hit_pulse(hit_pulse)
  );
  zero_run_detector #(.WIDTH(8), .CNT_W(4), .THRESHOLD(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a),
`ifdef ZRD_MASK_EN
    .mask(mask),
`endif
    .zero(zero1), .run_count(run_count1), .run_hit(run_hit1), .hit_pulse(hit_pulse1)
  );
  typedef struct {
    logic r, c, v;
    logic [7:0] a;
    logic z;
    logic [3:0] cnt;
    logic h, p;
  } vec_t;
  vec_t vt[$];
  task automatic add(input logic r, c, v, input logic [7:0] av, input logic z, input logic [3:0] cnt, input logic h, p);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.a = av; t.z = z; t.cnt = cnt; t.h = h; t.p = p;
    vt.push_back(t);
  endtask
  task automatic step(input logic r, c, v, input logic [7:0] av);
    @(negedge clk);
    rst = r; clear = c; in_valid = v; a = av;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic z, input logic [3:0] cnt, input logic h, p);
    chk({nm, " zero"}, 32'(zero), 32'(z));
    chk({nm, " run_count"}, 32'(run_count), 32'(cnt));
    chk({nm, " run_hit"}, 32'(run_hit), 32'(h));
    chk({nm, " hit_pulse"}, 32'(hit_pulse), 32'(p));
  endtask
  initial begin
    int pulses;
    add(1, 0, 1, 8'h00, 0, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 8'h01, 0, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 1, 2, 0, 0);
    add(0, 0, 1, 8'h00, 1, 3, 0, 0);
    add(0, 0, 1, 8'h00, 1, 4, 1, 1);
    add(0, 0, 1, 8'h00, 1, 5, 1, 0);
    add(0, 0, 0, 8'h55, 1, 5, 1, 0);
    add(0, 0, 1, 8'h80, 0, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 8'h07, 1, 1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 1, 2, 0, 0);
    add(0, 1, 1, 8'h00, 0, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 1, 2, 0, 0);
    add(0, 0, 1, 8'h00, 1, 3, 0, 0);
    add(0, 0, 1, 8'h00, 1, 4, 1, 1);
    add(0, 0, 1, 8'h00, 1, 5, 1, 0);
    add(1, 0, 1, 8'h00, 0, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 1'($urandom), 1'($urandom), 8'($urandom));
      chk_all($sformatf("reset%0d", i), 0, 0, 0, 0);
    end
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].c, vt[i].v, vt[i].a);
      chk_all($sformatf("vec%0d", i), vt[i].z, vt[i].cnt, vt[i].h, vt[i].p);
    end
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 1, 8'(i));
      chk($sformatf("sweep a=%0d zero", i), 32'(zero), 32'(i == 0));
      chk($sformatf("sweep a=%0d run_count", i), 32'(run_count), 32'(i == 0));
    end
    step(1, 0, 0, 8'h00);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 1, 8'h00);
      pulses += int'(hit_pulse);
      chk($sformatf("sat%0d run_count", i), 32'(run_count), 32'(i > 15 ? 15 : i));
      chk($sformatf("sat%0d run_hit", i), 32'(run_hit), 32'(i >= 4));
    end
    chk("sat pulse total", 32'(pulses), 32'd1);
    step(0, 0, 1, 8'h01);
    chk_all("sat break", 0, 0, 0, 0);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    chk("thr1 run_hit", 32'(run_hit1), 32'd1);
    chk("thr1 hit_pulse", 32'(hit_pulse1), 32'd1);
    chk("thr1 run_count", 32'(run_count1), 32'd1);
    chk("thr4 run_hit after one zero", 32'(run_hit), 32'd0);
    step(0, 0, 1, 8'h00);
    chk("thr1 second zero run_hit", 32'(run_hit1), 32'd1);
    chk("thr1 second zero hit_pulse", 32'(hit_pulse1), 32'd0);
    step(0, 0, 1, 8'h10);
    chk("thr1 nonzero run_hit", 32'(run_hit1), 32'd0);
    chk("thr1 nonzero run_count", 32'(run_count1), 32'd0);
`ifdef ZRD_MASK_EN
    mask = 8'hF0;
    step(0, 0, 1, 8'h0F);
    chk("mask F0 a=0F zero", 32'(zero), 32'd1);
    chk("mask F0 a=0F run_count", 32'(run_count), 32'd1);
    mask = 8'hFF;
    step(0, 0, 1, 8'h0F);
    chk("mask FF a=0F zero", 32'(zero), 32'd0);
    chk("mask FF a=0F run_count", 32'(run_count), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
